// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line input and received-byte/status outputs of the UART receiver.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_err;
    logic       parity_err;
    logic       busy;
    modport master (output rx, input data, data_valid, framing_err, parity_err, busy);
    modport slave  (input rx, output data, data_valid, framing_err, parity_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver, 8N1 by default or 8E1 with UART_RX_PARITY_EN defined.
// Holds the last good byte on data and pulses exactly one strobe per accepted or rejected frame.
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_s_d_q;
    logic [CW-1:0] div_q, div_d;
    logic [3:0]    tcnt_q, tcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          dv_q, dv_d, fe_q, fe_d;
    logic          tick, mid, last, stop_now;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d, pe_q, pe_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_s_d_q  <= 1'b1;
            div_q     <= '0;
            tcnt_q    <= 4'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_s_d_q  <= rx_s_q;
            div_q     <= div_d;
            tcnt_q    <= tcnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            pe_q      <= pe_d;
`endif
        end
    end

    // START samples mid-bit at tcnt 7; every later bit is 16 ticks on, i.e. tcnt 15 after the clear
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (rx_s_d_q && !rx_s_q) ? START : IDLE;
            START:   state_d = !mid ? START : rx_s_q ? IDLE : DATA;
            DATA:    state_d = (last && bit_q == 3'd7) ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
            PARITY:  state_d = last ? STOP : PARITY;
`endif
            STOP:    state_d = last ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick     = div_q == CW'(DIV - 1);
        div_d    = tick ? '0 : div_q + 1'b1;
        mid      = tick && tcnt_q == 4'd7;
        last     = tick && tcnt_q == 4'd15;
        tcnt_d   = (state_d != state_q) ? 4'd0 : tcnt_q + {3'd0, tick};
        bit_d    = (state_q != DATA) ? 3'd0 : bit_q + {2'd0, last};
        shift_d  = (state_q == DATA && last) ? {rx_s_q, shift_q[7:1]} : shift_q;
        stop_now = state_q == STOP && last;
`ifdef UART_RX_PARITY_EN
        par_bad_d = (state_q == PARITY && last) ? (rx_s_q != ^shift_q) : par_bad_q;
        pe_d      = stop_now && rx_s_q && par_bad_q;
        dv_d      = stop_now && rx_s_q && !par_bad_q;
`else
        dv_d      = stop_now && rx_s_q;
`endif
        fe_d     = stop_now && !rx_s_q;
        data_d   = dv_d ? shift_q : data_q;
    end

    always_comb begin
        bus.busy        = state_q != IDLE;
        bus.data        = data_q;
        bus.data_valid  = dv_q;
        bus.framing_err = fe_q;
`ifdef UART_RX_PARITY_EN
        bus.parity_err  = pe_q;
`else
        bus.parity_err  = 1'b0;
`endif
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frame vectors plus hand sequences for false start, back-to-back and reset abort.
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME = 176;
`else
    localparam int FRAME = 160;
`endif
    localparam int LAT = FRAME - 5;

    typedef struct {
        string      name;
        logic [7:0] val;
        bit         par_ok;
        logic       stop;
        int         hold;
        int         exp_dv;
        int         exp_fe;
        int         exp_pe;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0, bad = 0;
    int   dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, cyc = 0;
    int   busy_rise = -1, busy_fall = -1;
    logic busy_prev = 1'b0;
    logic [7:0] dv_data[$];
    int   dv_cycs[$];
    vec_t vecs[$];

    uart_rx_if bus();
    uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.data_valid) begin
            dv_cnt++;
            dv_data.push_back(bus.data);
            dv_cycs.push_back(cyc);
        end
        if (bus.framing_err) fe_cnt++;
        if (bus.parity_err) pe_cnt++;
        if (bus.data_valid || bus.framing_err || bus.parity_err)
            check("strobe_onehot_busy_low", {bus.busy, bus.data_valid, bus.framing_err, bus.parity_err},
                  {1'b0, bus.data_valid, !bus.data_valid && bus.framing_err, !bus.data_valid && !bus.framing_err});
        if (bus.busy && !busy_prev) busy_rise = cyc;
        if (!bus.busy && busy_prev) busy_fall = cyc;
        busy_prev = bus.busy;
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bit_(input logic lvl);
        bus.rx = lvl;
        wait_cyc(16);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        wait_cyc(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, output int t0);
        t0 = cyc;
        bit_(1'b0);
        for (int i = 0; i < 8; i++) bit_(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_(par);
`endif
        bit_(stop);
    endtask

    initial begin
        int t0, d0, f0, p0, n0;
        logic [7:0] cur;
        vecs.push_back('{"good_35", 8'h35, 1'b1, 1'b1, 0, 1, 0, 0, 8'h35});
        vecs.push_back('{"frame_err_a5", 8'hA5, 1'b1, 1'b0, 40, 0, 1, 0, 8'h35});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{"par_good_07", 8'h07, 1'b1, 1'b1, 0, 1, 0, 0, 8'h07});
        vecs.push_back('{"par_bad_07", 8'h07, 1'b0, 1'b1, 0, 0, 0, 1, 8'h07});
        vecs.push_back('{"par_and_stop_bad", 8'h5A, 1'b0, 1'b0, 0, 0, 1, 0, 8'h07});
`endif
        bus.rx = 1'b1;
        wait_cyc(3);
        check("rst_data", bus.data, 8'h00);
        check("rst_dv", bus.data_valid, 1'b0);
        check("rst_fe", bus.framing_err, 1'b0);
        check("rst_pe", bus.parity_err, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        idle(10);
        foreach (vecs[i]) begin
            d0 = dv_cnt; f0 = fe_cnt; p0 = pe_cnt;
            send_frame(vecs[i].val, ^vecs[i].val ^ !vecs[i].par_ok, vecs[i].stop, t0);
            wait_cyc(vecs[i].hold);
            idle(30);
            check({vecs[i].name, "_dv"}, dv_cnt - d0, vecs[i].exp_dv);
            check({vecs[i].name, "_fe"}, fe_cnt - f0, vecs[i].exp_fe);
            check({vecs[i].name, "_pe"}, pe_cnt - p0, vecs[i].exp_pe);
            check({vecs[i].name, "_data"}, bus.data, vecs[i].exp_data);
            check({vecs[i].name, "_busy"}, bus.busy, 1'b0);
            if (vecs[i].exp_dv == 1 && dv_cnt > d0)
                check({vecs[i].name, "_latency"}, dv_cycs[dv_cycs.size() - 1] - t0, LAT);
        end
        cur = bus.data;
        d0 = dv_cnt; f0 = fe_cnt; p0 = pe_cnt;
        t0 = cyc;
        bus.rx = 1'b0;
        wait_cyc(4);
        idle(30);
        check("false_busy_rise", busy_rise - t0, 3);
        check("false_busy_fall", busy_fall - t0, 11);
        check("false_strobes", (dv_cnt - d0) + (fe_cnt - f0) + (pe_cnt - p0), 0);
        check("false_data", bus.data, cur);
        n0 = dv_cnt;
        send_frame(8'h00, 1'b0, 1'b1, t0);
        send_frame(8'hFF, 1'b0, 1'b1, t0);
        idle(30);
        check("b2b_count", dv_cnt - n0, 2);
        if (dv_cnt - n0 == 2) begin
            check("b2b_first", dv_data[n0], 8'h00);
            check("b2b_second", dv_data[n0 + 1], 8'hFF);
            check("b2b_spacing", dv_cycs[n0 + 1] - dv_cycs[n0], FRAME);
        end
        d0 = dv_cnt; f0 = fe_cnt; p0 = pe_cnt;
        bit_(1'b0);
        repeat (3) bit_(1'b1);
        bus.rx = 1'b1;
        wait_cyc(8);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        check("abort_data", bus.data, 8'h00);
        check("abort_busy", bus.busy, 1'b0);
        idle(250);
        check("abort_strobes", (dv_cnt - d0) + (fe_cnt - f0) + (pe_cnt - p0), 0);
        check("abort_data_held", bus.data, 8'h00);
        d0 = dv_cnt;
        send_frame(8'h09, 1'b0, 1'b1, t0);
        idle(30);
        check("after_abort_dv", dv_cnt - d0, 1);
        check("after_abort_data", bus.data, 8'h09);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the board's serial input. Deserialises 8N1 frames (optional even parity) with 16x oversampling and holds the last good byte on `data`. `data` drives the seven-segment display decoder directly. Emits a one-cycle strobe per accepted byte and per rejected frame.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s. The oversample divisor is `DIV = CLK_FREQ/(BAUD*16)`, integer floor, and must be ≥1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle is high.
- `data`  out  8  last correctly framed byte, held until the next good frame.
- `data_valid`  out  1  one-cycle pulse in the cycle `data` updates.
- `framing_err`  out  1  one-cycle pulse when the stop bit samples low.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch. Constant 0 without the macro.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Input synchroniser:** `rx` passes through a 2-FF synchroniser to give `rx_s`. The block also keeps `rx_s_d`, a one-cycle delayed copy.
- **Tick generator:** a counter 0..DIV-1 emits `tick` when it reaches DIV-1. It runs continuously and is cleared only by reset.
- **Tick counter:** a 4-bit counter `tcnt` advances on each `tick` and is cleared on every state change.
- **IDLE:** a falling edge (`rx_s_d`=1, `rx_s`=0) moves to START. A constantly low line does not retrigger.
- **START:** at the tick where `tcnt`=7 (mid start bit), sample `rx_s`.
  - If it is 0, go to DATA with the bit index at 0.
  - If it is 1, the start was false: return to IDLE with no strobe.
- **DATA:** every 16 ticks from the START sample, sample `rx_s` into the shift register, LSB first. After bit 7, go to PARITY if the macro is defined, otherwise to STOP.
- **PARITY (macro only):** sample 16 ticks after bit 7 and compare with the even parity of the 8 data bits.
- **STOP:** sample 16 ticks after the previous sample, then return to IDLE.
  - Stop=1 and parity OK: load `data` from the shift register and pulse `data_valid`.
  - Stop=0: pulse `framing_err` and leave `data` unchanged.
  - Stop=1 and parity bad: pulse `parity_err` and leave `data` unchanged.
  - Framing has priority: if both the stop bit and parity are bad, only `framing_err` pulses.
- **Back-to-back frames:** a new start edge arriving right after the stop sample (the second half of the stop bit) is caught in IDLE.

## Timing
- **Reset values:** `data`=8'h00 (the display shows "0"), `data_valid`=0, `framing_err`=0, `parity_err`=0, `busy`=0. State returns to IDLE and the tick counter, `tcnt` and shift register clear.
- **Reset mid-frame:** aborts the frame with no strobe. Reception resumes on the next falling edge after reset deasserts.
- **Synchroniser latency:** 2 clk from `rx` to `rx_s`, plus 1 clk for edge detection.
- **Strobe timing:** `data_valid`, `framing_err` and `parity_err` are registered. They assert for exactly one clk, in the cycle after the clk carrying the stop-sample tick. `data` changes in the same cycle as `data_valid`.
- **Strobe exclusivity:** at most one strobe per frame, and the strobes are mutually exclusive.
- **`busy` timing:**
  - Rises in the clk after the falling edge is detected.
  - Falls in the same cycle as the frame's strobe.
  - After a false start, falls in the clk after the start sample.
- **Sampling point:** each bit is sampled within ±1 tick (±1/16 bit) of its nominal centre. End-to-end baud mismatch up to ±3% is tolerated.

## Configuration
- `UART_RX_PARITY_EN` defined: frames are 8E1. The PARITY state and parity check are present, and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: frames are 8N1. There is no PARITY state, and `parity_err` is tied 0.

## Test plan
All scenarios use `CLK_FREQ`=1_600_000 and `BAUD`=100_000, giving `DIV`=1 and one bit = 16 clk.
- **Reset state:** assert `reset` 3 clk with `rx`=1 -> `data`=0x00, all strobes 0, `busy`=0.
- **Good frame:** send 0x35 8N1 -> one `data_valid` pulse, `data`=0x35, `framing_err`=0, `busy` low after the strobe.
- **Framing error:** send 0xA5 with stop bit 0 after the 0x35 frame -> one `framing_err` pulse, no `data_valid`, `data` stays 0x35. Hold `rx` low 40 clk, then release -> no further strobes.
- **False start:** pulse `rx` low 4 clk in idle -> `busy` goes high then low, no strobes, `data` unchanged.
- **Back-to-back and reset abort:**
  - Send 0x00 then 0xFF with no idle gap -> two `data_valid` pulses 160 clk apart, `data` 0x00 then 0xFF.
  - Assert `reset` during data bit 3 of a third frame -> reset values, no strobe.
  - Send 0x09 -> `data`=0x09.
- **Parity (`UART_RX_PARITY_EN` defined):**
  - 0x07 with parity bit 1 -> `data_valid`, `data`=0x07.
  - 0x07 with parity bit 0 -> `parity_err` only, `data` stays 0x07.
  - Bad parity and bad stop together -> `framing_err` only.
